inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Requester side of the instruction-memory interface. Owns the program counter, drives
//  the fetch address to the combinational InstMemory and captures the returned word.
//  Buffers {pc,inst} pairs in a small FIFO and hands them to decode over a valid/ready
//  handshake. Supports halt (fetch_en) and control-flow redirect with buffer flush.
// PARAMETERS
//  WIDTH         32            address/instruction width
//  DEPTH         2             fetch FIFO entries (power of 2, >=2)
//  RESET_VECTOR  32'h1011100A  PC value loaded on reset
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  pc            out  WIDTH  fetch address to InstMemory (current PC register)
//  inst          in   WIDTH  instruction word from InstMemory, combinational from pc
//  fetch_en      in   1      1 = fetch allowed this cycle; 0 = halt fetching (drain continues)
//  redirect      in   1      1 = load redirect_pc and flush buffered entries
//  redirect_pc   in   WIDTH  redirect target
//  out_valid     out  1      head FIFO entry valid
//  out_ready     in   1      decode accepts head entry
//  out_pc        out  WIDTH  PC of head entry
//  out_inst      out  WIDTH  instruction of head entry
// BEHAVIOUR
//  Reset (async, immediate): PC=RESET_VECTOR, FIFO count=0, rd/wr ptr=0; out_valid=0,
//   out_pc=0, out_inst=0 (FIFO storage cleared). Outputs hold these until first edge after release.
//  deq = out_valid & out_ready. space = (count<DEPTH) | deq.
//  Per rising edge, priority order:
//   1. redirect=1: PC<=redirect_pc; count<=0, ptrs<=0 (flush, incl. any same-cycle deq);
//      current inst is NOT enqueued. deq still counts as accepted by decode.
//   2. else fetch_en & space: enqueue {pc,inst}; PC<=PC+4 (mod 2^WIDTH, wraps silently).
//   3. else: PC holds; no enqueue.
//   deq pops head unless flushed. Simultaneous enq+deq when full is legal; count unchanged.
//  Latency: word at PC enters FIFO on edge N, out_valid=1 after edge N (1 cycle after pc driven).
//  out_valid = (count!=0); out_pc/out_inst = head entry, stable while out_valid & ~out_ready.
//  Ordering: entries leave in fetch order; no loss, no duplication under any backpressure.
//  Alignment: no check; PC low bits carried as-is (reset vector is 2-mod-4).
//  Redirect while fetch_en=0: PC still loads, FIFO still flushes.
//  No combinational path from out_ready/redirect to pc (pc is a pure register output).
// STRUCTURE
//  Package rv_fetch_pkg: localparam RESET_VECTOR, INST_BYTES=4; typedef struct packed
//   {logic[31:0] pc; logic[31:0] inst;} fetch_entry_t.
//  Sub-module fetch_fifo (DEPTH x fetch_entry_t, push/pop/flush, count, full/empty,
//   async active-high reset). Top holds PC register and enqueue/redirect control.
// TESTING
//  1 Release rst, fetch_en=1, out_ready=1 -> out_pc 1011100A,1011100E,10111012,10111016 with
//    out_inst 00148493,0024F513,0014E493,0014C493 on consecutive cycles; out_valid=1 from edge 1.
//  2 out_ready=0 for 6 cycles after reset -> count saturates at 2, pc holds at 10111012,
//    head stays 1011100A; on out_ready=1 sequence continues with no gap/duplicate.
//  3 FIFO full, out_ready=1, redirect=1 redirect_pc=1011100E same cycle -> next out_pc=1011100E,
//    entries 1011100A/1011100E-old/10111012 stale never appear after flush.
//  4 redirect_pc=FFFFFFFE then free-run -> out_pc FFFFFFFE, 00000002, 00000006 (wrap).
//  5 Assert rst between edges mid-stream -> out_valid=0, pc=1011100A immediately, no edge needed.
//  6 fetch_en=0 with 2 buffered, out_ready=1 -> both drain in order, then out_valid=0, pc unchanged.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package rv_fetch_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h1011_100A;
    localparam int unsigned INST_BYTES   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage : rv_fetch_pkg

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc,inst} fetch entries with push/pop and synchronous flush.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_data_i,
    output fetch_entry_t head_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    fetch_entry_t        mem_q [DEPTH];
    logic [PW-1:0]       rd_ptr_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [CW-1:0]       count_q;
    logic                push_ok_s;
    logic                pop_ok_s;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == {CW{1'b0}});
    assign head_data_o = mem_q[rd_ptr_q];

    // A push into a full buffer is only honoured when the head leaves the same cycle.
    assign push_ok_s = push_i & (~full_o | pop_i);
    assign pop_ok_s  = pop_i & ~empty_o;

    // Pointer, occupancy and storage update; flush discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : fetch_fifo

// File: rtl/inst_fetch_unit.sv
// Instruction fetch requester: owns the PC, captures memory words and buffers them for decode.
module inst_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter int          DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = rv_fetch_pkg::RESET_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] inst,
    input  logic             fetch_en,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_inst
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             deq_s;
    logic             space_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_entry_s;

    assign deq_s   = out_valid & out_ready;
    assign space_s = ~full_s | deq_s;
    // A redirect flushes the buffer, which already covers any same-cycle dequeue.
    assign pop_s   = deq_s & ~redirect;

    assign push_entry_s = '{pc: pc_q, inst: inst};

    // Next-PC selection: redirect beats sequential fetch, otherwise hold.
    always_comb begin
        pc_d   = pc_q;
        push_s = 1'b0;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (fetch_en && space_s) begin
            push_s = 1'b1;
            pc_d   = pc_q + WIDTH'(INST_BYTES);
        end else begin
            pc_d = pc_q;
        end
    end

    // Program counter register; pc leaves the block straight from this flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .flush_i     (redirect),
        .push_data_i (push_entry_s),
        .head_data_o (head_entry_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    assign pc        = pc_q;
    assign out_valid = ~empty_s;
    assign out_pc    = head_entry_s.pc;
    assign out_inst  = head_entry_s.inst;

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table, directed corner sequences and a scoreboard.
module tb_inst_fetch_unit;
    import rv_fetch_pkg::*;

    localparam logic [31:0] RV = 32'h1011_100A;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int errors = 0;
    int checks = 0;

    logic [31:0]  ref_pc;
    fetch_entry_t ref_q[$];

    inst_fetch_unit #(.WIDTH(32), .DEPTH(2), .RESET_VECTOR(RV)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .inst        (inst),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h1011_100A: return 32'h0014_8493;
            32'h1011_100E: return 32'h0024_F513;
            32'h1011_1012: return 32'h0014_E493;
            32'h1011_1016: return 32'h0014_C493;
            default:       return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    assign inst = mem_word(pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_reset();
        ref_pc = RV;
        ref_q.delete();
    endtask

    // One clock: drive inputs, check against the scoreboard before the edge, advance the model.
    task automatic step(input logic fe, input logic rdy, input logic rd, input logic [31:0] rpc);
        logic deq;
        logic space;
        fetch_en    = fe;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        chk("pc", pc, ref_pc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, ref_q.size() != 0});
        if (ref_q.size() != 0) begin
            chk("sb_out_pc", out_pc, ref_q[0].pc);
            chk("sb_out_inst", out_inst, ref_q[0].inst);
        end
        deq   = (ref_q.size() != 0) && rdy;
        space = (ref_q.size() < 2) || deq;
        if (deq) void'(ref_q.pop_front());
        if (rd) begin
            ref_q.delete();
            ref_pc = rpc;
        end else if (fe && space) begin
            ref_q.push_back('{pc: ref_pc, inst: mem_word(ref_pc)});
            ref_pc = ref_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_en = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", pc, RV);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        rst = 1'b0;
        ref_reset();
    endtask

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_out_pc;
        logic [31:0] exp_out_inst;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h1011_100A, 32'h0014_8493, 32'h1011_100E};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h1011_100E, 32'h0024_F513, 32'h1011_1012};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h1011_1012, 32'h0014_E493, 32'h1011_1016};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h1011_1016, 32'h0014_C493, 32'h1011_101A};

        // Free-running fetch from reset, compared against the vector table.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(vecs[i].fe, vecs[i].rdy, 1'b0, 32'd0);
            chk("t1_valid", {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            chk("t1_out_pc", out_pc, vecs[i].exp_out_pc);
            chk("t1_out_inst", out_inst, vecs[i].exp_out_inst);
            chk("t1_pc", pc, vecs[i].exp_pc);
        end

        // Backpressure: buffer saturates, PC and head hold, then resume without gaps.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t2_pc_hold", pc, 32'h1011_1012);
        chk("t2_head_hold", out_pc, 32'h1011_100A);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t2_next_head", out_pc, 32'h1011_100E);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect while full and decode accepting: flush, then restart at target.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h1011_100E);
        chk("t3_flushed", {31'd0, out_valid}, 32'd0);
        chk("t3_pc", pc, 32'h1011_100E);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t3_head", out_pc, 32'h1011_100E);
        chk("t3_head_inst", out_inst, 32'h0024_F513);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // PC wrap past the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t4_pc0", out_pc, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t4_pc1", out_pc, 32'h0000_0002);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t4_pc2", out_pc, 32'h0000_0006);

        // Asynchronous reset between edges takes effect without a clock.
        #2;
        rst = 1'b1;
        #1;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_pc", pc, RV);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_reset();

        // Halt with two buffered entries: they drain in order while PC holds.
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t6_head", out_pc, 32'h1011_100E);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t6_empty", {31'd0, out_valid}, 32'd0);
        chk("t6_pc", pc, 32'h1011_1012);
        step(1'b0, 1'b1, 1'b0, 32'd0);

        // Random traffic against the scoreboard, including redirects near the wrap point.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, rpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_inst_fetch_unit
